// File: rtl/alu_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | alu_arbiter: round-robin valid/ready arbiter sharing one 8-bit ALU      |
// | between two requesters, with per-requester response regs and shadow     |
// | zero flags. Optional grant locking enabled by macro ALU_ARB_LOCK_EN.    |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module alu_arbiter #(
  parameter int W   = 8,
  parameter int Ops = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic [Ops-1:0] req0_op,
  input  logic           req0_setflags,
  input  logic           req0_lock,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  input  logic [Ops-1:0] req1_op,
  input  logic           req1_setflags,
  input  logic           req1_lock,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [Ops-1:0] alu_op,
  output logic           alu_setflags,
  input  logic [W-1:0]   alu_out,
  input  logic           alu_zero,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [W-1:0]   rsp0_data,
  output logic           rsp0_zero,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [W-1:0]   rsp1_data,
  output logic           rsp1_zero
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           rsp0_valid_q, rsp0_valid_d;
  logic           rsp1_valid_q, rsp1_valid_d;
  logic [W-1:0]   rsp0_data_q, rsp0_data_d;
  logic [W-1:0]   rsp1_data_q, rsp1_data_d;
  logic           zflag0_q, zflag0_d;
  logic           zflag1_q, zflag1_d;
  logic           elig0, elig1, grant0, grant1;

`ifndef ALU_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = req0_lock ^ req1_lock;
`endif

  // A slot is free if empty or being drained this cycle; a lock starves the non-owner.
  always_comb begin
    elig0  = req0_valid && (!rsp0_valid_q || rsp0_ready) && (state_q != LOCK1) && !Reset;
    elig1  = req1_valid && (!rsp1_valid_q || rsp1_ready) && (state_q != LOCK0) && !Reset;
    grant0 = elig0 && (!elig1 || last_grant_q);
    grant1 = elig1 && !grant0;
  end

  always_comb begin
    alu_a        = '0;
    alu_b        = '0;
    alu_op       = '0;
    alu_setflags = 1'b0;
    if (grant0) begin
      alu_a        = req0_a;
      alu_b        = req0_b;
      alu_op       = req0_op;
      alu_setflags = req0_setflags;
    end else if (grant1) begin
      alu_a        = req1_a;
      alu_b        = req1_b;
      alu_op       = req1_op;
      alu_setflags = req1_setflags;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    zflag0_d     = zflag0_q;
    zflag1_d     = zflag1_q;
    state_d      = state_q;

    if (rsp0_valid_q && rsp0_ready) rsp0_valid_d = 1'b0;
    if (rsp1_valid_q && rsp1_ready) rsp1_valid_d = 1'b0;

    // alu_zero is only meaningful when the granted op requested a flag update.
    if (grant0) begin
      last_grant_d = 1'b0;
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = alu_out;
      if (req0_setflags) zflag0_d = alu_zero;
    end
    if (grant1) begin
      last_grant_d = 1'b1;
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = alu_out;
      if (req1_setflags) zflag1_d = alu_zero;
    end

`ifdef ALU_ARB_LOCK_EN
    case (state_q)
      ARB: begin
        if (grant0 && req0_lock)      state_d = LOCK0;
        else if (grant1 && req1_lock) state_d = LOCK1;
      end
      LOCK0:   if (grant0 && !req0_lock) state_d = ARB;
      LOCK1:   if (grant1 && !req1_lock) state_d = ARB;
      default: state_d = ARB;
    endcase
`else
    state_d = ARB;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ARB;
      last_grant_q <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      zflag0_q     <= 1'b0;
      zflag1_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      zflag0_q     <= zflag0_d;
      zflag1_q     <= zflag1_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign rsp0_zero  = zflag0_q;
  assign rsp1_zero  = zflag1_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_alu_arbiter: scoreboard bench for alu_arbiter with a small ALU model |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_ORR = 4'h3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 0, req1_valid = 0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0] req0_op = 0, req1_op = 0;
  logic       req0_setflags = 0, req1_setflags = 0;
  logic       req0_lock = 0, req1_lock = 0;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_op;
  logic       alu_setflags, alu_zero;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready = 1, rsp1_ready = 1;
  logic [7:0] rsp0_data, rsp1_data;
  logic       rsp0_zero, rsp1_zero;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp0_q[$];
  logic [8:0] exp1_q[$];
  logic zf0 = 0, zf1 = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(8), .Ops(4)) dut (
    .Clk(clk), .Reset(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_setflags(req0_setflags), .req0_lock(req0_lock),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_setflags(req1_setflags), .req1_lock(req1_lock),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_setflags(alu_setflags),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero)
  );

  always_comb begin
    alu_out = 8'h00;
    case (alu_op)
      OP_ADD:  alu_out = alu_a + alu_b;
      OP_SUB:  alu_out = alu_a - alu_b;
      OP_AND:  alu_out = alu_a & alu_b;
      OP_ORR:  alu_out = alu_a | alu_b;
      default: alu_out = 8'h00;
    endcase
    alu_zero = (alu_out == 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response handshake pops one expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp0_valid && rsp0_ready) begin
        if (exp0_q.size() == 0) chk("rsp0_unexpected", 1, 0);
        else begin
          logic [8:0] e;
          e = exp0_q.pop_front();
          chk("rsp0_data", {24'h0, rsp0_data}, {24'h0, e[7:0]});
          chk("rsp0_zero", {31'h0, rsp0_zero}, {31'h0, e[8]});
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (exp1_q.size() == 0) chk("rsp1_unexpected", 1, 0);
        else begin
          logic [8:0] e;
          e = exp1_q.pop_front();
          chk("rsp1_data", {24'h0, rsp1_data}, {24'h0, e[7:0]});
          chk("rsp1_zero", {31'h0, rsp1_zero}, {31'h0, e[8]});
        end
      end
    end
  end

  // One cycle: check grants and ALU drive, record expected responses.
  task automatic step(input bit g0, input bit g1, input logic [7:0] d0, input logic [7:0] d1);
    @(negedge clk);
    chk("req0_ready", {31'h0, req0_ready}, {31'h0, g0});
    chk("req1_ready", {31'h0, req1_ready}, {31'h0, g1});
    if (g0) begin
      chk("alu_drive0", {11'h0, alu_a, alu_b, alu_op, alu_setflags},
          {11'h0, req0_a, req0_b, req0_op, req0_setflags});
      if (req0_setflags) zf0 = (d0 == 8'h00);
      exp0_q.push_back({zf0, d0});
    end else if (g1) begin
      chk("alu_drive1", {11'h0, alu_a, alu_b, alu_op, alu_setflags},
          {11'h0, req1_a, req1_b, req1_op, req1_setflags});
      if (req1_setflags) zf1 = (d1 == 8'h00);
      exp1_q.push_back({zf1, d1});
    end else begin
      chk("alu_idle", {11'h0, alu_a, alu_b, alu_op, alu_setflags}, 32'h0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 0;
    req1_valid = 0;
    step(0, 0, 8'h00, 8'h00);
  endtask

  task automatic do_reset(input int cycles);
    req0_valid = 0;
    req1_valid = 0;
    rst = 1;
    repeat (cycles) begin
      @(negedge clk);
      chk("rst_ready", {30'h0, req0_ready, req1_ready}, 32'h0);
      @(posedge clk);
      #1;
    end
    exp0_q.delete();
    exp1_q.delete();
    zf0 = 0;
    zf1 = 0;
    rst = 0;
    @(negedge clk);
    chk("rst_rsp_valid", {30'h0, rsp0_valid, rsp1_valid}, 32'h0);
    chk("rst_rsp_data", {16'h0, rsp0_data, rsp1_data}, 32'h0);
    chk("rst_rsp_zero", {30'h0, rsp0_zero, rsp1_zero}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic sf, input logic lk);
    req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; req0_setflags = sf; req0_lock = lk;
  endtask

  task automatic set1(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic sf, input logic lk);
    req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; req1_setflags = sf; req1_lock = lk;
  endtask

  initial begin
    int gseq[$];
    int k;

    // Reset with a pending request: no grant may leak out.
    req0_valid = 1;
    rst = 1;
    @(negedge clk);
    chk("rst_ready_held", {31'h0, req0_ready}, 32'h0);
    chk("rst_alu_idle", {11'h0, alu_a, alu_b, alu_op, alu_setflags}, 32'h0);
    @(posedge clk);
    #1;
    do_reset(1);

    // Single ADD with flags.
    set0(OP_ADD, 8'h05, 8'h03, 1, 0);
    step(1, 0, 8'h08, 8'h00);
    idle();

    // Both requesters saturating from reset: strict alternation starting at 0.
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      set0(OP_ADD, 8'(i), 8'h01, 0, 0);
      set1(OP_ADD, 8'(8'h10 + i), 8'h02, 0, 0);
      step((i % 2) == 0, (i % 2) == 1, 8'(i + 1), 8'(8'h12 + i));
    end
    idle();

    // Shadow flags stay per requester.
    set0(OP_SUB, 8'h07, 8'h07, 1, 0);
    step(1, 0, 8'h00, 8'h00);
    req0_valid = 0;
    set1(OP_ORR, 8'h00, 8'h00, 0, 0);
    step(0, 1, 8'h00, 8'h00);
    req1_valid = 0;
    set0(OP_ADD, 8'h01, 8'h01, 0, 0);
    step(1, 0, 8'h02, 8'h00);
    idle();

    // Back-pressure on response 0 blocks requester 0 only.
    rsp0_ready = 0;
    set0(OP_ADD, 8'h02, 8'h02, 0, 0);
    step(1, 0, 8'h04, 8'h00);
    set0(OP_ADD, 8'h03, 8'h03, 0, 0);
    for (int i = 0; i < 3; i++) begin
      set1(OP_AND, 8'(8'h20 + i), 8'h0F, 0, 0);
      step(0, 1, 8'h00, 8'(i));
    end
    rsp0_ready = 1;
    step(1, 0, 8'h06, 8'h00);
    idle();

    // Lock sequence; last_grant set to 1 first so requester 0 takes the tie.
    set1(OP_ADD, 8'h40, 8'h01, 0, 0);
    step(0, 1, 8'h00, 8'h41);
`ifdef ALU_ARB_LOCK_EN
    gseq = '{0, 0, 0, 0, 0, 1};
`else
    gseq = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif
    k = 0;
    foreach (gseq[c]) begin
      if (k < 5) set0(OP_ADD, 8'(k), 8'h10, 0, (k < 4));
      else req0_valid = 0;
      set1(OP_ADD, 8'h40, 8'h01, 0, 0);
      step(gseq[c] == 0, gseq[c] == 1, 8'(8'h10 + k), 8'h41);
      if (gseq[c] == 0) k++;
    end
    idle();

    // Reset while locked with a response pending on requester 1.
    rsp1_ready = 0;
    set1(OP_ADD, 8'h01, 8'h02, 0, 0);
    step(0, 1, 8'h00, 8'h03);
    req1_valid = 0;
    set0(OP_SUB, 8'h05, 8'h05, 1, 1);
    step(1, 0, 8'h00, 8'h00);
    do_reset(1);
    rsp1_ready = 1;
    set0(OP_ADD, 8'h11, 8'h22, 0, 0);
    set1(OP_ADD, 8'h33, 8'h44, 0, 0);
    step(1, 0, 8'h33, 8'h00);
    req0_valid = 0;
    step(0, 1, 8'h00, 8'h77);
    idle();
    idle();

    chk("scoreboard_drained", exp0_q.size() + exp1_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational 8-bit ALU between two requesters, requester 0 (core datapath) and requester 1 (auxiliary sequencer), using a round-robin, valid/ready handshake. Each granted operation is issued to the ALU for one cycle. Its result is captured into a per-requester response register, and each requester gets its own shadow zero flag so the two flag contexts never mix. The block sits between the requesters and the ALU's InputA/InputB/OP/SetFlags/Out/Zero pins.

## Interface
- W, 8, data width (matches ALU)
- Ops, 4, opcode width (matches ALU; encodings from package definitions)
- Clk  input  1  clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- req0_valid / req1_valid  input  1  operation request
- req0_ready / req1_ready  output  1  grant; transfer occurs when valid && ready
- req0_a / req1_a  input  W  operand A
- req0_b / req1_b  input  W  operand B
- req0_op / req1_op  input  Ops  ALU opcode
- req0_setflags / req1_setflags  input  1  update this requester's zero flag
- req0_lock / req1_lock  input  1  hold grant after this op (ALU_ARB_LOCK_EN only)
- alu_a, alu_b  output  W  to ALU InputA/InputB
- alu_op  output  Ops  to ALU OP
- alu_setflags  output  1  to ALU SetFlags
- alu_out  input  W  from ALU Out
- alu_zero  input  1  from ALU Zero
- rsp0_valid / rsp1_valid  output  1  response pending
- rsp0_ready / rsp1_ready  input  1  response consumed when valid && ready
- rsp0_data / rsp1_data  output  W  registered result
- rsp0_zero / rsp1_zero  output  1  requester's shadow zero flag after its op

## Operation
- Eligibility: eligible_n = reqn_valid && (!rspn_valid || rspn_ready). A response being consumed in the same cycle frees its slot.
- Arbitration uses the register last_grant. If both requesters are eligible, the one != last_grant wins. If only one is eligible, it wins. At most one reqn_ready is high per cycle. On a grant, last_grant takes the winner's index.
- Issue: the winner's a/b/op/setflags drive alu_* combinationally in the grant cycle.
- Idle (no grant): alu_a = 0, alu_b = 0, alu_op = 0, alu_setflags = 0.
- Capture at the end of the grant cycle:
  - rspn_data <= alu_out and rspn_valid <= 1.
  - If setflags is high, the shadow flag zflag_n <= alu_zero. Otherwise zflag_n holds.
- rspn_zero always equals zflag_n.
- The ALU's own Zero is valid only in cycles where the arbiter drives alu_setflags = 1. It is never sampled otherwise.
- rspn_valid clears on rspn_valid && rspn_ready, unless a new grant to the same requester occurs in that cycle. In that case it stays 1 with the new data.
- FSM states:
  - ARB: round-robin as above.
  - LOCK0 / LOCK1: only the owner is eligible, and the other requester's ready stays 0.
- FSM transitions:
  - ARB -> LOCKn on a grant to n with reqn_lock = 1.
  - LOCKn -> ARB on a grant to n with reqn_lock = 0.
  - LOCKn holds while the owner is idle. There is no timeout.
- No arithmetic in the arbiter. Widths pass through unchanged.

## Timing
- Grant: combinational from valid, in the same cycle.
- Result latency: 1 cycle. The op is granted in cycle N, and rspn_valid/rspn_data/rspn_zero are visible in cycle N+1.
- Throughput: 1 op/cycle total. A single requester sustains 1 op/cycle if it keeps rspn_ready high.
- Reset values:
  - rsp0/1_valid = 0, rsp0/1_data = 0, rsp0/1_zero = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - FSM = ARB.
  - req0/1_ready = 0 while Reset is high.
  - alu_* = idle values.
- Reset mid-operation: an in-flight capture is discarded, the lock is dropped, and the shadow flags clear.
- Simultaneous grant and response consume for the same requester: the new data wins, and valid stays high.

## Configuration
- ALU_ARB_LOCK_EN defined: the reqn_lock inputs are honoured, and the LOCK0/LOCK1 states exist.
- ALU_ARB_LOCK_EN undefined: the lock inputs are ignored, the FSM stays permanently in ARB, and arbitration is pure round-robin.

## Test plan
- Req0 only, ADD a = 0x05, b = 0x03, setflags = 1 -> req0_ready = 1 in the same cycle; next cycle rsp0_valid = 1, rsp0_data = 0x08, rsp0_zero = 0.
- Both requesters valid every cycle from reset, rsp_ready = 1 -> grants 0, 1, 0, 1, …; each rspn_valid high on alternate cycles with the correct data.
- Req0 SUB 0x07 − 0x07 with setflags = 1, then req1 ORR 0x00 | 0x00 with setflags = 0 -> rsp0_zero = 1, rsp1_data = 0x00, rsp1_zero = 0; zflag0 stays 1.
- rsp0_ready held 0 with rsp0_valid = 1, req0 and req1 both valid -> req0_ready = 0 and req1 granted every cycle. Raise rsp0_ready -> req0 is granted in that same cycle.
- Lock (macro on): req0 ADD with lock = 1, then three ops with lock = 1, then lock = 0, with req1 valid throughout -> req1_ready = 0 until the cycle after the lock = 0 grant. With the macro off, the same stimulus alternates grants.
- Reset asserted for 1 cycle while in LOCK0 with rsp1_valid = 1 -> next cycle FSM = ARB, all rsp*_valid = 0, zflags = 0, and requester 0 wins the next tie.
